// File: rtl/priority_pkg.sv
// Types and helpers shared by the fixed-priority encoder and its request collector.
package priority_pkg;

  typedef enum logic [1:0] {
    SCAN,
    WAIT,
    OFFER
  } state_t;

  // One-hot decode of idx into an n-bit mask (n <= 32); out-of-range indices give zero.
  function automatic logic [31:0] onehot(input logic [31:0] idx, input int unsigned n);
    logic [31:0] mask;
    mask = '0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((i < n) && (idx == i)) begin
        mask[i] = 1'b1;
      end
    end
    return mask;
  endfunction

endpackage

// File: rtl/req_collector_if.sv
// Grant channel from the request collector to its downstream consumer.
interface req_collector_if #(
  parameter int N = 8
);
  localparam int IW = $clog2(N);

  logic          grant_valid;
  logic [IW-1:0] grant_idx;
  logic          grant_ready;

  modport master (
    output grant_valid,
    output grant_idx,
    input  grant_ready
  );

  modport slave (
    input  grant_valid,
    input  grant_idx,
    output grant_ready
  );
endinterface

// File: rtl/req_collector.sv
// Collects request pulses into a sticky pending vector, feeds the priority encoder
// and turns its registered result into a valid/ready grant.
module req_collector
  import priority_pkg::*;
#(
  parameter  int N     = 8,
  parameter  int CNT_W = 8,
  localparam int IW    = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     req_pulse,
  output logic [N-1:0]     enc_req,
  input  logic             enc_valid,
  input  logic [IW-1:0]    enc_idx,
  req_collector_if.master  gnt,
  output logic [CNT_W-1:0] coalesce_cnt,
  output logic             enc_err
);

  state_t        state, state_next;
  logic [N-1:0]  pending, pending_next;
  logic [N-1:0]  grant_mask, clr_mask, enc_mask;
  logic [IW-1:0] grant_idx_q, grant_idx_next;
  logic          err_next;
  logic          accept;
  logic          coalesce_hit;

  assign accept     = (state == OFFER) && gnt.grant_ready;
  assign grant_mask = N'(onehot(32'(grant_idx_q), N));
  assign enc_mask   = N'(onehot(32'(enc_idx), N));
  assign clr_mask   = accept ? grant_mask : '0;

  // Set wins over clear: a fresh pulse on the line being serviced stays pending.
  assign pending_next = (pending & ~clr_mask) | req_pulse;
  assign coalesce_hit = |(req_pulse & pending & ~clr_mask);

  assign enc_req         = pending;
  assign gnt.grant_valid = (state == OFFER);
  assign gnt.grant_idx   = grant_idx_q;

  always_comb begin
    state_next     = state;
    grant_idx_next = grant_idx_q;
    err_next       = enc_err;
    unique case (state)
      SCAN: state_next = WAIT;
      WAIT: begin
        if (enc_valid) begin
          state_next     = OFFER;
          grant_idx_next = enc_idx;
          if (!(|(pending & enc_mask))) begin
            err_next = 1'b1;
          end
        end else begin
          state_next = SCAN;
        end
      end
      OFFER: begin
        if (gnt.grant_ready) begin
          state_next = SCAN;
        end
      end
      default: state_next = SCAN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= SCAN;
      pending      <= '0;
      grant_idx_q  <= '0;
      enc_err      <= 1'b0;
      coalesce_cnt <= '0;
    end else begin
      state       <= state_next;
      pending     <= pending_next;
      grant_idx_q <= grant_idx_next;
      enc_err     <= err_next;
      if (coalesce_hit && (coalesce_cnt != '1)) begin
        coalesce_cnt <= coalesce_cnt + CNT_W'(1);
      end
    end
  end

  // A faulty encoder result is reported via enc_err, so the pending check is waived then.
  a_grant_pending: assert property (@(posedge clk) disable iff (!rst_n || enc_err)
    gnt.grant_valid |-> |(pending & grant_mask));

  a_grant_stable: assert property (@(posedge clk) disable iff (!rst_n)
    (gnt.grant_valid && !gnt.grant_ready) |=> (gnt.grant_valid && $stable(grant_idx_q)));

  a_grant_source: assert property (@(posedge clk) disable iff (!rst_n)
    $rose(gnt.grant_valid) |-> $past((state == WAIT) && enc_valid));

endmodule

// File: tb/tb_req_collector.sv
// Bench for req_collector wired to a registered fixed-priority encoder model,
// checked every cycle against a transaction-level reference model.
module tb_req_collector;
  import priority_pkg::*;

  localparam int N     = 8;
  localparam int CNT_W = 8;
  localparam int IW    = $clog2(N);
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [N-1:0]     req_pulse = '0;
  logic [N-1:0]     enc_req;
  logic             enc_valid;
  logic [IW-1:0]    enc_idx;
  logic [CNT_W-1:0] coalesce_cnt;
  logic             enc_err;
  logic             force_en = 1'b0;
  logic [IW-1:0]    force_idx = '0;

  int checks = 0;
  int errors = 0;

  req_collector_if #(.N(N)) gnt ();

  always #5 clk = ~clk;

  req_collector #(.N(N), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_pulse    (req_pulse),
    .enc_req      (enc_req),
    .enc_valid    (enc_valid),
    .enc_idx      (enc_idx),
    .gnt          (gnt),
    .coalesce_cnt (coalesce_cnt),
    .enc_err      (enc_err)
  );

  function automatic int lowest(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) begin
      if (v[i]) return i;
    end
    return 0;
  endfunction

  // Registered fixed-priority encoder, with an override to emulate a faulty encoder.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      enc_valid <= 1'b0;
      enc_idx   <= '0;
    end else if (force_en) begin
      enc_valid <= 1'b1;
      enc_idx   <= force_idx;
    end else begin
      enc_valid <= |enc_req;
      enc_idx   <= IW'(lowest(enc_req));
    end
  end

  // Reference model: a grant slot alternates "look" and "decide" while idle; a decided
  // grant is held until accepted. Decisions use the pending set seen at the look slot.
  logic [N-1:0] m_pend, m_snap;
  bit           m_gv, m_err, m_sf;
  int           m_gi, m_cnt, m_slot, m_sfi;

  always @(posedge clk or negedge rst_n) begin : model
    logic [N-1:0] p, snap, clr;
    bit gv, err, sf;
    int gi, cnt, slot, sfi;
    if (!rst_n) begin
      m_pend <= '0; m_snap <= '0; m_gv <= 1'b0; m_err <= 1'b0; m_sf <= 1'b0;
      m_gi <= 0; m_cnt <= 0; m_slot <= 0; m_sfi <= 0;
    end else begin
      p = m_pend; snap = m_snap; gv = m_gv; err = m_err; sf = m_sf;
      gi = m_gi; cnt = m_cnt; slot = m_slot; sfi = m_sfi;
      clr = (gv && gnt.grant_ready) ? (N'(1) << gi) : '0;
      if (((req_pulse & p & ~clr) != '0) && (cnt < CMAX)) cnt++;
      if (gv) begin
        if (gnt.grant_ready) gv = 1'b0;
      end else if (slot == 0) begin
        snap = p; sf = force_en; sfi = int'(force_idx); slot = 1;
      end else begin
        slot = 0;
        if (sf || (snap != '0)) begin
          gv = 1'b1;
          gi = sf ? sfi : lowest(snap);
          if (!p[gi]) err = 1'b1;
        end
      end
      p = (p & ~clr) | req_pulse;
      m_pend <= p; m_snap <= snap; m_gv <= gv; m_err <= err; m_sf <= sf;
      m_gi <= gi; m_cnt <= cnt; m_slot <= slot; m_sfi <= sfi;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      chk("model_enc_req", 32'(enc_req), 32'(m_pend));
      chk("model_grant_valid", 32'(gnt.grant_valid), 32'(m_gv));
      if (m_gv) chk("model_grant_idx", 32'(gnt.grant_idx), m_gi);
      chk("model_coalesce_cnt", 32'(coalesce_cnt), m_cnt);
      chk("model_enc_err", 32'(enc_err), 32'(m_err));
    end
  end

  task automatic wait_gv(input string name);
    int n = 0;
    while (!gnt.grant_valid && n < 12) begin
      @(negedge clk);
      n++;
    end
    if (!gnt.grant_valid) begin
      checks++;
      errors++;
      $display("FAIL %s: grant_valid timeout, got 0, expected 1", name);
    end
  endtask

  task automatic pulse(input logic [N-1:0] v);
    req_pulse = v;
    @(negedge clk);
    req_pulse = '0;
  endtask

  task automatic idle(input int n);
    req_pulse = '0;
    gnt.grant_ready = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int grants0;
    gnt.grant_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle_grant_valid", 32'(gnt.grant_valid), 0);
      chk("idle_enc_req", 32'(enc_req), 0);
    end

    // Two lines in one pulse are served in priority order, three cycles apart.
    pulse(8'b0010_0100);
    wait_gv("two_first");
    chk("two_first_idx", 32'(gnt.grant_idx), 2);
    repeat (3) @(negedge clk);
    chk("two_second_valid", 32'(gnt.grant_valid), 1);
    chk("two_second_idx", 32'(gnt.grant_idx), 5);
    @(negedge clk);
    chk("two_drained", 32'(enc_req), 0);
    chk("two_cnt", 32'(coalesce_cnt), 0);

    // Stalled grant holds its index; a repeat pulse coalesces into one service.
    gnt.grant_ready = 1'b0;
    pulse(8'h08);
    wait_gv("stall");
    chk("stall_idx", 32'(gnt.grant_idx), 3);
    for (int i = 0; i < 5; i++) begin
      req_pulse = (i == 1) ? 8'h08 : 8'h00;
      @(negedge clk);
      chk("stall_valid", 32'(gnt.grant_valid), 1);
      chk("stall_idx_held", 32'(gnt.grant_idx), 3);
    end
    req_pulse = '0;
    chk("stall_cnt", 32'(coalesce_cnt), 1);
    gnt.grant_ready = 1'b1;
    @(negedge clk);
    chk("stall_cleared", 32'(enc_req & 8'h08), 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("stall_single", 32'(gnt.grant_valid), 0);
    end

    // Re-request in the acceptance cycle survives the clear.
    gnt.grant_ready = 1'b0;
    pulse(8'h10);
    wait_gv("rereq");
    chk("rereq_idx", 32'(gnt.grant_idx), 4);
    gnt.grant_ready = 1'b1;
    pulse(8'h10);
    chk("rereq_pending", 32'(enc_req & 8'h10), 32'h10);
    chk("rereq_gap", 32'(gnt.grant_valid), 0);
    repeat (2) @(negedge clk);
    chk("rereq_second_valid", 32'(gnt.grant_valid), 1);
    chk("rereq_second_idx", 32'(gnt.grant_idx), 4);
    idle(6);
    chk("rereq_cnt", 32'(coalesce_cnt), 1);

    // Randomised traffic with random back-pressure.
    for (int i = 0; i < 1500; i++) begin
      req_pulse = N'($urandom & $urandom & $urandom);
      gnt.grant_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
    end
    idle(30);
    chk("random_drained", 32'(enc_req), 0);

    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_cnt", 32'(coalesce_cnt), 0);

    // Continuous pulses on line 0 saturate the counter while grants keep flowing.
    grants0 = 0;
    for (int i = 0; i < 450; i++) begin
      req_pulse = 8'h01;
      @(negedge clk);
      if (gnt.grant_valid && gnt.grant_idx == 0) grants0++;
    end
    req_pulse = '0;
    chk("sat_cnt", 32'(coalesce_cnt), CMAX);
    chk("sat_grants_flow", 32'(grants0 >= 140), 1);
    idle(10);
    chk("sat_cnt_hold", 32'(coalesce_cnt), CMAX);

    // Encoder reports a line that is not pending.
    force_en = 1'b1;
    force_idx = 3'd6;
    pulse(8'h01);
    repeat (4) @(negedge clk);
    force_en = 1'b0;
    idle(10);
    chk("err_set", 32'(enc_err), 1);
    pulse(8'h04);
    idle(10);
    chk("err_sticky", 32'(enc_err), 1);

    // Reset while a grant is being offered.
    gnt.grant_ready = 1'b0;
    pulse(8'h08);
    wait_gv("rst_offer");
    rst_n = 1'b0;
    #1;
    chk("rst_grant_valid", 32'(gnt.grant_valid), 0);
    chk("rst_grant_idx", 32'(gnt.grant_idx), 0);
    chk("rst_enc_req", 32'(enc_req), 0);
    chk("rst_cnt2", 32'(coalesce_cnt), 0);
    chk("rst_err", 32'(enc_err), 0);
    @(negedge clk);
    rst_n = 1'b1;
    gnt.grant_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("post_rst_idle", 32'(gnt.grant_valid), 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

endmodule
